// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: IMEM read port, redirect input and the decode-side valid/ready handshake.
// master = fetch unit, slave = IMEM/decode environment.
interface instr_fetch_unit_if;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   modport master (
      input  fetch_en, imem_data, redirect_valid, redirect_pc, out_ready,
      output imem_addr, imem_req, out_valid, out_pc, out_instr
   );

   modport slave (
      output fetch_en, imem_data, redirect_valid, redirect_pc, out_ready,
      input  imem_addr, imem_req, out_valid, out_pc, out_instr
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC generator + instruction queue feeding decode; redirects flush the queue and squash in-flight reads.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/squash_cnt performance counters.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_fetch_unit_if.master   bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          fetch_cnt,
   output logic [31:0]          squash_cnt
`endif
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_e                     state_q, state_d;
   logic [31:0]                pc_q, pc_d;
   logic [31:0]                req_pc_q, req_pc_d;
   logic                       inflight_q, inflight_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   entry_t [FIFO_DEPTH-1:0]    mem_q;

   logic        issue, push, pop, squash, empty, bypass, wr_en, rd_en;
   logic [CNT_W:0] occ;
   entry_t      push_ent, head;

   // FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.fetch_en)  state_d = RUN;
         RUN:     if (!bus.fetch_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Issue/response/handshake decode
   always_comb begin
      empty    = (count_q == '0);
      occ      = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
      issue    = (state_q == RUN) && !bus.redirect_valid && (occ < DEPTH_C);
      push     = inflight_q && !bus.redirect_valid;
      squash   = inflight_q && bus.redirect_valid;
      push_ent = '{pc: req_pc_q, instr: bus.imem_data};
      // An arriving word is shown straight away when the queue is empty, so a
      // depth-2 queue still sustains one instruction per cycle.
      bypass   = empty && push;
      head     = bypass ? push_ent : mem_q[rd_ptr_q];
      pop      = (!empty || push) && !bus.redirect_valid && bus.out_ready;
      wr_en    = push && !(bypass && pop);
      rd_en    = pop && !empty;
   end

   assign bus.imem_req  = issue;
   assign bus.imem_addr = {2'b00, pc_q[31:2]};
   assign bus.out_valid = (!empty || push) && !bus.redirect_valid;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;

   // Next-state datapath
   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (bus.redirect_valid) begin
         pc_d     = bus.redirect_pc & 32'hFFFF_FFFC;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (issue) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
         end
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (wr_en && !bus.redirect_valid) mem_q[wr_ptr_q] <= push_ent;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Flushed entries and the discarded response both count as squashed work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt  <= '0;
         squash_cnt <= '0;
      end else begin
         if (pop) fetch_cnt <= fetch_cnt + 32'd1;
         if (bus.redirect_valid)
            squash_cnt <= squash_cnt + 32'(count_q) + 32'(squash);
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit plus hand sequences for reset and wrap corners.
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit_if bus();
   instr_fetch_unit_if bus2();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fcnt, scnt, fcnt2, scnt2;
`endif

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt(fcnt), .squash_cnt(scnt)
`endif
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .bus(bus2)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt(fcnt2), .squash_cnt(scnt2)
`endif
   );

   // IMEM models: one-cycle read latency
   always @(posedge clk or negedge rst_n)
      if (!rst_n) bus.imem_data <= '0;
      else if (bus.imem_req) bus.imem_data <= bus.imem_addr ^ 32'hA5A5_0000;

   always @(posedge clk or negedge rst2_n)
      if (!rst2_n) bus2.imem_data <= '0;
      else if (bus2.imem_req) bus2.imem_data <= bus2.imem_addr ^ 32'hA5A5_0000;

   typedef struct {
      logic        fe;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic req, input logic [31:0] addr, input logic vld,
                      input logic [31:0] pc, input logic [31:0] instr);
      vec_t v;
      v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.instr = instr;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   int hs;
   logic got;
   int n2;
   logic [31:0] pc2 [2];
   logic [31:0] in2 [2];

   initial begin
      bus.fetch_en = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b1;
      bus2.fetch_en = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0; bus2.out_ready = 1'b1;
      hs = 0;

      //   fe rv rpc        rdy req addr       vld pc         instr
      add(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'h1,   1, 32'h0,   32'hA5A5_0000);
      add(1, 0, 32'h0,   1, 1, 32'h2,   1, 32'h4,   32'hA5A5_0001);
      add(1, 0, 32'h0,   1, 1, 32'h3,   1, 32'h8,   32'hA5A5_0002);
      add(1, 0, 32'h0,   0, 1, 32'h4,   1, 32'hC,   32'hA5A5_0003);
      for (int k = 0; k < 4; k++)
         add(1, 0, 32'h0, 0, 0, 32'h5, 1, 32'hC, 32'hA5A5_0003);
      add(1, 0, 32'h0,   1, 0, 32'h5,   1, 32'hC,   32'hA5A5_0003);
      add(1, 0, 32'h0,   1, 1, 32'h5,   1, 32'h10,  32'hA5A5_0004);
      add(1, 0, 32'h0,   1, 1, 32'h6,   1, 32'h14,  32'hA5A5_0005);
      add(1, 0, 32'h0,   0, 1, 32'h7,   1, 32'h18,  32'hA5A5_0006);
      add(1, 1, 32'h100, 1, 0, 32'h8,   0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'h40,  0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'h41,  1, 32'h100, 32'hA5A5_0040);
      add(1, 0, 32'h0,   1, 1, 32'h42,  1, 32'h104, 32'hA5A5_0041);
      add(1, 1, 32'h103, 1, 0, 32'h43,  0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'h40,  0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'h41,  1, 32'h100, 32'hA5A5_0040);
      add(1, 1, 32'h200, 1, 0, 32'h42,  0, 32'h0,   32'h0);
      add(1, 1, 32'h300, 1, 0, 32'h80,  0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'hC0,  0, 32'h0,   32'h0);
      add(1, 0, 32'h0,   1, 1, 32'hC1,  1, 32'h300, 32'hA5A5_00C0);
      add(0, 0, 32'h0,   1, 1, 32'hC2,  1, 32'h304, 32'hA5A5_00C1);
      add(0, 0, 32'h0,   1, 0, 32'hC3,  1, 32'h308, 32'hA5A5_00C2);
      add(0, 0, 32'h0,   1, 0, 32'hC3,  0, 32'h0,   32'h0);
      add(0, 1, 32'h400, 1, 0, 32'hC3,  0, 32'h0,   32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h100, 0, 32'h0,   32'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   32'(bus.imem_req),  32'h0);
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_addr",  bus.imem_addr,      32'h0);
      chk("rst_pc",    bus.out_pc,         32'h0);
      chk("rst_instr", bus.out_instr,      32'h0);
      chk("rst2_addr", bus2.imem_addr,     32'h3FFF_FFFF);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_fcnt", fcnt, 32'h0);
      chk("rst_scnt", scnt, 32'h0);
`endif
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         bus.fetch_en       = tbl[i].fe;
         bus.redirect_valid = tbl[i].rv;
         bus.redirect_pc    = tbl[i].rpc;
         bus.out_ready      = tbl[i].rdy;
         #1;
         chk($sformatf("c%0d_req", i),   32'(bus.imem_req),  32'(tbl[i].req));
         chk($sformatf("c%0d_addr", i),  bus.imem_addr,      tbl[i].addr);
         chk($sformatf("c%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].vld));
         if (tbl[i].vld) begin
            chk($sformatf("c%0d_pc", i),    bus.out_pc,    tbl[i].pc);
            chk($sformatf("c%0d_instr", i), bus.out_instr, tbl[i].instr);
            if (tbl[i].rdy) hs++;
         end
`ifdef FETCH_PERF_CNT_EN
         if (i == 15) chk("scnt_after_redirect", scnt, 32'd2);
`endif
         @(posedge clk);
         #1;
      end
      bus.redirect_valid = 1'b0;

`ifdef FETCH_PERF_CNT_EN
      chk("fcnt_handshakes", fcnt, 32'(hs));
      chk("scnt_total",      scnt, 32'd4);
`endif

      // Fill the queue, then reset mid-stream
      bus.fetch_en  = 1'b1;
      bus.out_ready = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("full_valid", 32'(bus.out_valid), 32'h1);
      chk("full_req",   32'(bus.imem_req),  32'h0);
      chk("full_pc",    bus.out_pc,         32'h400);
      chk("full_instr", bus.out_instr,      32'hA5A5_0100);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(bus.out_valid), 32'h0);
      chk("midrst_req",   32'(bus.imem_req),  32'h0);
      chk("midrst_addr",  bus.imem_addr,      32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("midrst_fcnt", fcnt, 32'h0);
      chk("midrst_scnt", scnt, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) got = 1'b1;
      end
      chk("postrst_seen",  32'(got),       32'h1);
      chk("postrst_pc",    bus.out_pc,     32'h0);
      chk("postrst_instr", bus.out_instr,  32'hA5A5_0000);

      // PC wrap from 32'hFFFF_FFFC
      @(posedge clk);
      #1;
      rst2_n = 1'b1;
      n2 = 0;
      for (int k = 0; k < 20 && n2 < 2; k++) begin
         @(posedge clk);
         #1;
         if (bus2.out_valid) begin
            pc2[n2] = bus2.out_pc;
            in2[n2] = bus2.out_instr;
            n2++;
         end
      end
      chk("wrap_count", 32'(n2), 32'd2);
      if (n2 == 2) begin
         chk("wrap_pc0",    pc2[0], 32'hFFFF_FFFC);
         chk("wrap_instr0", in2[0], 32'h9A5A_FFFF);
         chk("wrap_pc1",    pc2[1], 32'h0);
         chk("wrap_instr1", in2[1], 32'hA5A5_0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
